uart_rx: RTL

Serial receiver stage of the UART path. It consumes the 16x oversampling strobe produced by the baud rate generator (`rx_clk`, one `clk` cycle wide) and the asynchronous `rx` line. It recovers 8N1 frames (optionally 8E1) and writes each good byte into the write side of the asynchronous FIFO. It also flags framing, parity and overrun errors.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and sample points.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  function automatic int unsigned mid_tick(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int unsigned last_tick(input int unsigned oversample);
    return oversample - 1;
  endfunction

  localparam int unsigned MID_SAMPLE = DEFAULT_OVERSAMPLE / 2 - 1;
  localparam int unsigned LAST_TICK  = DEFAULT_OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-FIFO signal bundle; slave is the receiver side, master the environment side.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = uart_pkg::DEFAULT_DATA_BITS
);
  logic                 rx_tick;
  logic                 rx;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport slave (
    input  rx_tick, rx, fifo_full,
    output rx_data, rx_valid, busy, frame_err, overrun_err
`ifdef UART_RX_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output rx_tick, rx, fifo_full,
    input  rx_data, rx_valid, busy, frame_err, overrun_err
`ifdef UART_RX_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/uart_sync.sv
// N-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 frames by default, 8E1 when UART_RX_PARITY_EN is defined.
// Good bytes are written to the FIFO write port; framing/parity/overrun are one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        reset,
  uart_rx_if.slave   bus
);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] LP_MID      = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] LP_LAST     = TW'(last_tick(OVERSAMPLE));
  localparam logic [BW-1:0] LP_LAST_BIT = BW'(DATA_BITS - 1);

  logic                 w_rxs;
  logic                 w_par_ok;
  logic [TW-1:0]        w_tick_next;

  rx_state_e            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_rxs_prev;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_parity_err;
`endif

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx),
    .o_q   (w_rxs)
  );

  assign w_tick_next = (r_tick_cnt == LP_LAST) ? '0 : r_tick_cnt + 1'b1;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_ok = ~^{r_shift, r_par_bit};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_rxs_prev    <= 1'b1;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_rxs_prev    <= w_rxs;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      unique case (r_state)
        // Edge detect runs every clk so a line parked low can never start a frame.
        StIdle: begin
          if (r_rxs_prev && !w_rxs) begin
            r_tick_cnt <= '0;
            r_state    <= StStart;
          end
        end
        StStart: begin
          if (bus.rx_tick) begin
            if (r_tick_cnt == LP_MID) begin
              if (w_rxs) begin
                r_state <= StIdle;
              end else begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_state    <= StData;
              end
            end else begin
              r_tick_cnt <= w_tick_next;
            end
          end
        end
        StData: begin
          if (bus.rx_tick) begin
            r_tick_cnt <= w_tick_next;
            if (r_tick_cnt == LP_LAST) begin
              r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == LP_LAST_BIT) begin
                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= StParity;
`else
                r_state   <= StStop;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (bus.rx_tick) begin
            r_tick_cnt <= w_tick_next;
            if (r_tick_cnt == LP_LAST) begin
              r_par_bit <= w_rxs;
              r_state   <= StStop;
            end
          end
        end
`endif
        StStop: begin
          if (bus.rx_tick) begin
            r_tick_cnt <= w_tick_next;
            if (r_tick_cnt == LP_LAST) begin
              r_state     <= StIdle;
              r_frame_err <= !w_rxs;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= !w_par_ok;
`endif
              // Any line error suppresses both delivery and overrun reporting.
              if (w_rxs && w_par_ok) begin
                if (bus.fifo_full) begin
                  r_overrun_err <= 1'b1;
                end else begin
                  r_rx_data  <= r_shift;
                  r_rx_valid <= 1'b1;
                end
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.busy        = (r_state != StIdle);
  assign bus.frame_err   = r_frame_err;
  assign bus.overrun_err = r_overrun_err;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = r_parity_err;
`endif
endmodule
